// File: rtl/fft_stream_adapter_if.sv
// fft_stream_adapter_if
//   Bundles every streaming signal around the FFT framing adapter: the
//   upstream sample stream (din_*), the core input (sink_*), the core output
//   (source_*), the downstream stream (dout_*) and the sticky frame_err flag.
//
//   modport master : the surrounding system (symbol source, FFT core,
//                    downstream consumer). It drives the adapter's inputs.
//   modport slave  : the adapter itself.
//
//   Parameters must match the adapter instance they connect to.
interface fft_stream_adapter_if #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 6,
    parameter int EXP_W = 6
);
    // upstream sample stream
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] din_real;
    logic [WIDTH-1:0] din_imag;
    logic             din_inverse;

    // core input
    logic             sink_valid;
    logic             sink_ready;
    logic             sink_sop;
    logic             sink_eop;
    logic [WIDTH-1:0] sink_real;
    logic [WIDTH-1:0] sink_imag;
    logic [1:0]       sink_error;
    logic             inverse;

    // core output
    logic             source_valid;
    logic             source_ready;
    logic             source_sop;
    logic             source_eop;
    logic [1:0]       source_error;
    logic [EXP_W-1:0] source_exp;
    logic [WIDTH-1:0] source_real;
    logic [WIDTH-1:0] source_imag;

    // downstream stream
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_sop;
    logic             dout_eop;
    logic [LOG2N-1:0] dout_index;
    logic [EXP_W-1:0] dout_exp;
    logic [WIDTH-1:0] dout_real;
    logic [WIDTH-1:0] dout_imag;

    logic             frame_err;

    modport master (
        output din_valid, din_real, din_imag, din_inverse,
        input  din_ready,
        output sink_ready,
        input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
               sink_error, inverse,
        output source_valid, source_sop, source_eop, source_error,
               source_exp, source_real, source_imag,
        input  source_ready,
        output dout_ready,
        input  dout_valid, dout_sop, dout_eop, dout_index, dout_exp,
               dout_real, dout_imag,
        input  frame_err
    );

    modport slave (
        input  din_valid, din_real, din_imag, din_inverse,
        output din_ready,
        input  sink_ready,
        output sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
               sink_error, inverse,
        input  source_valid, source_sop, source_eop, source_error,
               source_exp, source_real, source_imag,
        output source_ready,
        input  dout_ready,
        output dout_valid, dout_sop, dout_eop, dout_index, dout_exp,
               dout_real, dout_imag,
        output frame_err
    );
endinterface

// File: rtl/fft_stream_adapter.sv
// fft_stream_adapter
//   Avalon-ST framing adapter around an external N-point FFT/IFFT core
//   (N = 2**LOG2N).
//   Input side : one register slice from din_* to sink_*. Counts samples to
//                generate sink_sop/sink_eop and latches the transform
//                direction (inverse) on the first sample of each frame.
//   Output side: one register slice from source_* to dout_*. Adds the sample
//                index and the frame exponent and raises the sticky frame_err
//                on packet-framing violations.
//
// Ports
//   ifft_clk   : clock
//   ifft_rst_n : synchronous active-low reset
//   bus        : fft_stream_adapter_if.slave, all stream signals
module fft_stream_adapter #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 6,
    parameter int EXP_W = 6
) (
    input  logic                 ifft_clk,
    input  logic                 ifft_rst_n,
    fft_stream_adapter_if.slave  bus
);

    localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};
    localparam logic [LOG2N-1:0] CNT_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic [LOG2N-1:0] in_cnt_q,     in_cnt_d;
    logic             sink_valid_q, sink_valid_d;
    logic             sink_sop_q,   sink_sop_d;
    logic             sink_eop_q,   sink_eop_d;
    logic [WIDTH-1:0] sink_real_q,  sink_real_d;
    logic [WIDTH-1:0] sink_imag_q,  sink_imag_d;
    logic             inverse_q,    inverse_d;

    logic din_ready;
    logic din_fire;

    // Slice may refill in the same cycle the core drains it.
    assign din_ready = !sink_valid_q || bus.sink_ready;
    assign din_fire  = bus.din_valid && din_ready;

    always_comb begin
        in_cnt_d     = in_cnt_q;
        sink_valid_d = sink_valid_q;
        sink_sop_d   = sink_sop_q;
        sink_eop_d   = sink_eop_q;
        sink_real_d  = sink_real_q;
        sink_imag_d  = sink_imag_q;
        inverse_d    = inverse_q;

        if (din_fire) begin
            sink_valid_d = 1'b1;
            sink_real_d  = bus.din_real;
            sink_imag_d  = bus.din_imag;
            sink_sop_d   = (in_cnt_q == '0);
            sink_eop_d   = (in_cnt_q == LAST_IDX);
            in_cnt_d     = (in_cnt_q == LAST_IDX) ? '0 : in_cnt_q + CNT_ONE;
            // Direction is a frame property: only the first sample sets it.
            if (in_cnt_q == '0) begin
                inverse_d = bus.din_inverse;
            end
        end else if (bus.sink_ready) begin
            sink_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ifft_clk) begin
        if (!ifft_rst_n) begin
            in_cnt_q     <= '0;
            sink_valid_q <= 1'b0;
            sink_sop_q   <= 1'b0;
            sink_eop_q   <= 1'b0;
            sink_real_q  <= '0;
            sink_imag_q  <= '0;
            inverse_q    <= 1'b0;
        end else begin
            in_cnt_q     <= in_cnt_d;
            sink_valid_q <= sink_valid_d;
            sink_sop_q   <= sink_sop_d;
            sink_eop_q   <= sink_eop_d;
            sink_real_q  <= sink_real_d;
            sink_imag_q  <= sink_imag_d;
            inverse_q    <= inverse_d;
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.sink_valid = sink_valid_q;
    assign bus.sink_sop   = sink_sop_q;
    assign bus.sink_eop   = sink_eop_q;
    assign bus.sink_real  = sink_real_q;
    assign bus.sink_imag  = sink_imag_q;
    assign bus.sink_error = 2'b00;
    assign bus.inverse    = inverse_q;

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic [LOG2N-1:0] out_cnt_q,    out_cnt_d;
    logic [EXP_W-1:0] frame_exp_q,  frame_exp_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_sop_q,   dout_sop_d;
    logic             dout_eop_q,   dout_eop_d;
    logic [LOG2N-1:0] dout_index_q, dout_index_d;
    logic [EXP_W-1:0] dout_exp_q,   dout_exp_d;
    logic [WIDTH-1:0] dout_real_q,  dout_real_d;
    logic [WIDTH-1:0] dout_imag_q,  dout_imag_d;
    logic             frame_err_q,  frame_err_d;

    logic             source_ready;
    logic             src_fire;
    logic [LOG2N-1:0] beat_idx;
    logic             viol;

    assign source_ready = !dout_valid_q || bus.dout_ready;
    assign src_fire     = bus.source_valid && source_ready;

    // A sop beat is index 0 even when it interrupts a frame.
    assign beat_idx = bus.source_sop ? '0 : out_cnt_q;

    assign viol = ( bus.source_sop && (out_cnt_q != '0))       // restart mid-frame
                | (!bus.source_sop && (out_cnt_q == '0))       // beat outside a frame
                | ( bus.source_eop && (beat_idx  != LAST_IDX)) // eop at wrong index
                | (!bus.source_eop && (beat_idx  == LAST_IDX)) // missing eop
                | (bus.source_error != 2'b00);

    always_comb begin
        out_cnt_d    = out_cnt_q;
        frame_exp_d  = frame_exp_q;
        dout_valid_d = dout_valid_q;
        dout_sop_d   = dout_sop_q;
        dout_eop_d   = dout_eop_q;
        dout_index_d = dout_index_q;
        dout_exp_d   = dout_exp_q;
        dout_real_d  = dout_real_q;
        dout_imag_d  = dout_imag_q;
        frame_err_d  = frame_err_q;

        if (src_fire) begin
            dout_valid_d = 1'b1;
            dout_sop_d   = bus.source_sop;
            dout_eop_d   = bus.source_eop;
            dout_real_d  = bus.source_real;
            dout_imag_d  = bus.source_imag;
            dout_index_d = beat_idx;

            // The core only presents a valid exponent with sop.
            if (bus.source_sop) begin
                frame_exp_d = bus.source_exp;
                dout_exp_d  = bus.source_exp;
            end else begin
                dout_exp_d  = frame_exp_q;
            end

            if (bus.source_eop) begin
                out_cnt_d = '0;
            end else if (bus.source_sop) begin
                out_cnt_d = CNT_ONE;
            end else begin
                out_cnt_d = (out_cnt_q == LAST_IDX) ? '0 : out_cnt_q + CNT_ONE;
            end

            // Set has priority over the clean-sop clear.
            if (viol) begin
                frame_err_d = 1'b1;
            end else if (bus.source_sop) begin
                frame_err_d = 1'b0;
            end
        end else if (bus.dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ifft_clk) begin
        if (!ifft_rst_n) begin
            out_cnt_q    <= '0;
            frame_exp_q  <= '0;
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
            dout_index_q <= '0;
            dout_exp_q   <= '0;
            dout_real_q  <= '0;
            dout_imag_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            out_cnt_q    <= out_cnt_d;
            frame_exp_q  <= frame_exp_d;
            dout_valid_q <= dout_valid_d;
            dout_sop_q   <= dout_sop_d;
            dout_eop_q   <= dout_eop_d;
            dout_index_q <= dout_index_d;
            dout_exp_q   <= dout_exp_d;
            dout_real_q  <= dout_real_d;
            dout_imag_q  <= dout_imag_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.source_ready = source_ready;
    assign bus.dout_valid   = dout_valid_q;
    assign bus.dout_sop     = dout_sop_q;
    assign bus.dout_eop     = dout_eop_q;
    assign bus.dout_index   = dout_index_q;
    assign bus.dout_exp     = dout_exp_q;
    assign bus.dout_real    = dout_real_q;
    assign bus.dout_imag    = dout_imag_q;
    assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_fft_stream_adapter.sv
// tb_fft_stream_adapter
//   Directed bench for fft_stream_adapter. dut_a runs with N=64, dut_b with
//   N=8. Inputs change 1 time unit after the rising edge; outputs are
//   sampled 1 time unit after that.
module tb_fft_stream_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n;
    logic rst_b_n;
    int   checks   = 0;
    int   failures = 0;

    fft_stream_adapter_if #(.WIDTH(16), .LOG2N(6), .EXP_W(6)) ifa ();
    fft_stream_adapter_if #(.WIDTH(16), .LOG2N(3), .EXP_W(6)) ifb ();

    fft_stream_adapter #(.WIDTH(16), .LOG2N(6), .EXP_W(6)) dut_a (
        .ifft_clk   (clk),
        .ifft_rst_n (rst_a_n),
        .bus        (ifa.slave)
    );

    fft_stream_adapter #(.WIDTH(16), .LOG2N(3), .EXP_W(6)) dut_b (
        .ifft_clk   (clk),
        .ifft_rst_n (rst_b_n),
        .bus        (ifb.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ifa.din_valid = 0; ifa.din_real = '0; ifa.din_imag = '0; ifa.din_inverse = 0;
        ifa.sink_ready = 1; ifa.dout_ready = 1;
        ifa.source_valid = 0; ifa.source_sop = 0; ifa.source_eop = 0;
        ifa.source_error = '0; ifa.source_exp = '0; ifa.source_real = '0; ifa.source_imag = '0;
        ifb.din_valid = 0; ifb.din_real = '0; ifb.din_imag = '0; ifb.din_inverse = 0;
        ifb.sink_ready = 1; ifb.dout_ready = 1;
        ifb.source_valid = 0; ifb.source_sop = 0; ifb.source_eop = 0;
        ifb.source_error = '0; ifb.source_exp = '0; ifb.source_real = '0; ifb.source_imag = '0;
    endtask

    task automatic drive_src(input logic sop, input logic eop, input logic [5:0] e,
                             input logic [15:0] r);
        ifa.source_valid = 1;
        ifa.source_sop   = sop;
        ifa.source_eop   = eop;
        ifa.source_exp   = e;
        ifa.source_real  = r;
        ifa.source_imag  = ~r;
        ifa.source_error = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_a_n = 0;
        rst_b_n = 0;
        repeat (3) tick();
        #1;
        checks++; if (ifa.sink_valid !== 1'b0) begin failures++; $display("FAIL reset_sink_valid actual=%0b required=0", ifa.sink_valid); end
        checks++; if (ifa.sink_sop !== 1'b0) begin failures++; $display("FAIL reset_sink_sop actual=%0b required=0", ifa.sink_sop); end
        checks++; if (ifa.inverse !== 1'b0) begin failures++; $display("FAIL reset_inverse actual=%0b required=0", ifa.inverse); end
        checks++; if (ifa.sink_error !== 2'b00) begin failures++; $display("FAIL reset_sink_error actual=%0h required=0", ifa.sink_error); end
        checks++; if (ifa.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid actual=%0b required=0", ifa.dout_valid); end
        checks++; if (ifa.dout_index !== 6'd0) begin failures++; $display("FAIL reset_dout_index actual=%0d required=0", ifa.dout_index); end
        checks++; if (ifa.dout_exp !== 6'd0) begin failures++; $display("FAIL reset_dout_exp actual=%0h required=0", ifa.dout_exp); end
        checks++; if (ifa.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err actual=%0b required=0", ifa.frame_err); end
        checks++; if (ifa.din_ready !== 1'b1) begin failures++; $display("FAIL reset_din_ready actual=%0b required=1", ifa.din_ready); end
        checks++; if (ifa.source_ready !== 1'b1) begin failures++; $display("FAIL reset_source_ready actual=%0b required=1", ifa.source_ready); end
        checks++; if (ifb.sink_valid !== 1'b0) begin failures++; $display("FAIL reset_b_sink_valid actual=%0b required=0", ifb.sink_valid); end
        rst_a_n = 1;
        rst_b_n = 1;
        tick();
    endtask

    task automatic test_full_frame;
        ifa.sink_ready = 1;
        for (int k = 0; k < 64; k++) begin
            ifa.din_valid   = 1;
            ifa.din_real    = 16'(k * 3 + 7);
            ifa.din_imag    = 16'(-k);
            ifa.din_inverse = 0;
            #1;
            checks++; if (ifa.din_ready !== 1'b1) begin failures++; $display("FAIL ff_din_ready k=%0d actual=%0b required=1", k, ifa.din_ready); end
            tick();
            checks++; if (ifa.sink_valid !== 1'b1) begin failures++; $display("FAIL ff_sink_valid k=%0d actual=%0b required=1", k, ifa.sink_valid); end
            checks++; if (ifa.sink_real !== 16'(k * 3 + 7)) begin failures++; $display("FAIL ff_sink_real k=%0d actual=%0h required=%0h", k, ifa.sink_real, 16'(k * 3 + 7)); end
            checks++; if (ifa.sink_imag !== 16'(-k)) begin failures++; $display("FAIL ff_sink_imag k=%0d actual=%0h required=%0h", k, ifa.sink_imag, 16'(-k)); end
            checks++; if (ifa.sink_sop !== (k == 0)) begin failures++; $display("FAIL ff_sink_sop k=%0d actual=%0b required=%0b", k, ifa.sink_sop, (k == 0)); end
            checks++; if (ifa.sink_eop !== (k == 63)) begin failures++; $display("FAIL ff_sink_eop k=%0d actual=%0b required=%0b", k, ifa.sink_eop, (k == 63)); end
        end
        ifa.din_valid = 0;
        tick();
        checks++; if (ifa.sink_valid !== 1'b0) begin failures++; $display("FAIL ff_sink_idle actual=%0b required=0", ifa.sink_valid); end
    endtask

    task automatic test_gapped_inverse;
        logic [4:0] pat;
        logic       v;
        int         sent;
        int         sops;
        int         eops;
        pat  = 5'b01101;
        sent = 0;
        sops = 0;
        eops = 0;
        ifb.sink_ready = 1;
        for (int cyc = 0; cyc < 40 && sent < 8; cyc++) begin
            v = pat[cyc % 5];
            ifb.din_valid   = v;
            ifb.din_real    = 16'(200 + sent);
            // gap cycles carry 1 to show direction is only taken at frame start
            ifb.din_inverse = v ? (sent == 0) : 1'b1;
            tick();
            if (v) begin
                checks++; if (ifb.sink_valid !== 1'b1) begin failures++; $display("FAIL gap_sink_valid s=%0d actual=%0b required=1", sent, ifb.sink_valid); end
                checks++; if (ifb.sink_real !== 16'(200 + sent)) begin failures++; $display("FAIL gap_sink_real s=%0d actual=%0h required=%0h", sent, ifb.sink_real, 16'(200 + sent)); end
                checks++; if (ifb.sink_sop !== (sent == 0)) begin failures++; $display("FAIL gap_sink_sop s=%0d actual=%0b required=%0b", sent, ifb.sink_sop, (sent == 0)); end
                checks++; if (ifb.sink_eop !== (sent == 7)) begin failures++; $display("FAIL gap_sink_eop s=%0d actual=%0b required=%0b", sent, ifb.sink_eop, (sent == 7)); end
                checks++; if (ifb.inverse !== 1'b1) begin failures++; $display("FAIL gap_inverse s=%0d actual=%0b required=1", sent, ifb.inverse); end
                if (ifb.sink_sop === 1'b1) sops++;
                if (ifb.sink_eop === 1'b1) eops++;
                sent++;
            end else begin
                checks++; if (ifb.sink_valid !== 1'b0) begin failures++; $display("FAIL gap_sink_gap s=%0d actual=%0b required=0", sent, ifb.sink_valid); end
            end
        end
        checks++; if (sops != 1) begin failures++; $display("FAIL gap_sop_count actual=%0d required=1", sops); end
        checks++; if (eops != 1) begin failures++; $display("FAIL gap_eop_count actual=%0d required=1", eops); end
        ifb.din_valid = 0;
        tick();
    endtask

    task automatic test_backpressure;
        logic [15:0] q[$];
        logic [15:0] held;
        logic        stall;
        int          j;
        int          got;
        j    = 0;
        got  = 0;
        held = '0;
        for (int cyc = 0; cyc < 60 && got < 20; cyc++) begin
            stall           = (cyc >= 6 && cyc <= 8);
            ifa.sink_ready  = !stall;
            ifa.din_valid   = (j < 20);
            ifa.din_real    = 16'(500 + j);
            ifa.din_imag    = 16'(j);
            ifa.din_inverse = (j == 0);
            #1;
            checks++; if (ifa.din_ready !== !stall) begin failures++; $display("FAIL bp_din_ready cyc=%0d actual=%0b required=%0b", cyc, ifa.din_ready, !stall); end
            if (stall) begin
                if (cyc == 6) held = ifa.sink_real;
                else begin
                    checks++; if (ifa.sink_real !== held) begin failures++; $display("FAIL bp_frozen cyc=%0d actual=%0h required=%0h", cyc, ifa.sink_real, held); end
                end
                checks++; if (ifa.sink_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_hold cyc=%0d actual=%0b required=1", cyc, ifa.sink_valid); end
            end
            if (ifa.sink_valid === 1'b1 && ifa.sink_ready === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL bp_extra_sample actual=%0h required=none", ifa.sink_real);
                end else begin
                    if (ifa.sink_real !== q[0]) begin failures++; $display("FAIL bp_data n=%0d actual=%0h required=%0h", got, ifa.sink_real, q[0]); end
                    void'(q.pop_front());
                end
                checks++; if (ifa.sink_sop !== (got == 0)) begin failures++; $display("FAIL bp_sop n=%0d actual=%0b required=%0b", got, ifa.sink_sop, (got == 0)); end
                got++;
            end
            if (ifa.din_valid && !stall) begin
                q.push_back(16'(500 + j));
                j++;
            end
            tick();
        end
        checks++; if (got != 20) begin failures++; $display("FAIL bp_count actual=%0d required=20", got); end
        checks++; if (ifa.inverse !== 1'b1) begin failures++; $display("FAIL bp_inverse actual=%0b required=1", ifa.inverse); end
        ifa.din_valid  = 0;
        ifa.sink_ready = 1;
        tick();
    endtask

    task automatic test_core_output;
        int i;
        int oi;
        i  = 0;
        oi = 0;
        for (int cyc = 0; cyc < 400 && oi < 64; cyc++) begin
            ifa.dout_ready   = (cyc % 2 == 0);
            ifa.source_valid = (i < 64);
            ifa.source_sop   = (i == 0);
            ifa.source_eop   = (i == 63);
            ifa.source_exp   = (i == 0) ? 6'h3A : 6'h05;
            ifa.source_real  = 16'(1000 + i);
            ifa.source_imag  = 16'(2000 - i);
            ifa.source_error = '0;
            #1;
            if (ifa.dout_valid === 1'b1 && ifa.dout_ready === 1'b1) begin
                checks++; if (ifa.dout_index !== 6'(oi)) begin failures++; $display("FAIL co_index n=%0d actual=%0d required=%0d", oi, ifa.dout_index, oi); end
                checks++; if (ifa.dout_exp !== 6'h3A) begin failures++; $display("FAIL co_exp n=%0d actual=%0h required=3a", oi, ifa.dout_exp); end
                checks++; if (ifa.dout_real !== 16'(1000 + oi)) begin failures++; $display("FAIL co_real n=%0d actual=%0h required=%0h", oi, ifa.dout_real, 16'(1000 + oi)); end
                checks++; if (ifa.dout_imag !== 16'(2000 - oi)) begin failures++; $display("FAIL co_imag n=%0d actual=%0h required=%0h", oi, ifa.dout_imag, 16'(2000 - oi)); end
                checks++; if (ifa.dout_sop !== (oi == 0)) begin failures++; $display("FAIL co_sop n=%0d actual=%0b required=%0b", oi, ifa.dout_sop, (oi == 0)); end
                checks++; if (ifa.dout_eop !== (oi == 63)) begin failures++; $display("FAIL co_eop n=%0d actual=%0b required=%0b", oi, ifa.dout_eop, (oi == 63)); end
                oi++;
            end
            if (ifa.source_valid === 1'b1 && ifa.source_ready === 1'b1) i++;
            tick();
        end
        checks++; if (oi != 64) begin failures++; $display("FAIL co_beat_count actual=%0d required=64", oi); end
        checks++; if (ifa.frame_err !== 1'b0) begin failures++; $display("FAIL co_frame_err actual=%0b required=0", ifa.frame_err); end
        ifa.source_valid = 0;
        ifa.dout_ready   = 1;
        tick();
    endtask

    task automatic test_frame_error;
        ifa.dout_ready = 1;
        for (int k = 0; k < 10; k++) begin
            drive_src(k == 0, 1'b0, (k == 0) ? 6'h3A : 6'h00, 16'(k));
            tick();
        end
        checks++; if (ifa.frame_err !== 1'b0) begin failures++; $display("FAIL fe_before actual=%0b required=0", ifa.frame_err); end
        checks++; if (ifa.dout_index !== 6'd9) begin failures++; $display("FAIL fe_idx9 actual=%0d required=9", ifa.dout_index); end

        // restart on beat 10
        drive_src(1'b1, 1'b0, 6'h11, 16'd100);
        tick();
        checks++; if (ifa.frame_err !== 1'b1) begin failures++; $display("FAIL fe_restart_err actual=%0b required=1", ifa.frame_err); end
        checks++; if (ifa.dout_index !== 6'd0) begin failures++; $display("FAIL fe_restart_idx actual=%0d required=0", ifa.dout_index); end
        checks++; if (ifa.dout_sop !== 1'b1) begin failures++; $display("FAIL fe_restart_sop actual=%0b required=1", ifa.dout_sop); end
        checks++; if (ifa.dout_exp !== 6'h11) begin failures++; $display("FAIL fe_restart_exp actual=%0h required=11", ifa.dout_exp); end
        for (int k = 1; k < 64; k++) begin
            drive_src(1'b0, k == 63, 6'h00, 16'(100 + k));
            tick();
            if (k == 32) begin
                checks++; if (ifa.dout_exp !== 6'h11) begin failures++; $display("FAIL fe_mid_exp actual=%0h required=11", ifa.dout_exp); end
                checks++; if (ifa.dout_index !== 6'd32) begin failures++; $display("FAIL fe_mid_idx actual=%0d required=32", ifa.dout_index); end
            end
        end
        checks++; if (ifa.frame_err !== 1'b1) begin failures++; $display("FAIL fe_sticky actual=%0b required=1", ifa.frame_err); end
        checks++; if (ifa.dout_eop !== 1'b1) begin failures++; $display("FAIL fe_eop actual=%0b required=1", ifa.dout_eop); end

        // clean frame clears the flag at its sop
        drive_src(1'b1, 1'b0, 6'h22, 16'd0);
        tick();
        checks++; if (ifa.frame_err !== 1'b0) begin failures++; $display("FAIL fe_clear actual=%0b required=0", ifa.frame_err); end
        checks++; if (ifa.dout_exp !== 6'h22) begin failures++; $display("FAIL fe_clean_exp actual=%0h required=22", ifa.dout_exp); end
        for (int k = 1; k < 64; k++) begin
            drive_src(1'b0, k == 63, 6'h3F, 16'(k));
            tick();
        end
        checks++; if (ifa.frame_err !== 1'b0) begin failures++; $display("FAIL fe_clean_end actual=%0b required=0", ifa.frame_err); end
        checks++; if (ifa.dout_index !== 6'd63) begin failures++; $display("FAIL fe_clean_idx actual=%0d required=63", ifa.dout_index); end
        checks++; if (ifa.dout_exp !== 6'h22) begin failures++; $display("FAIL fe_clean_last_exp actual=%0h required=22", ifa.dout_exp); end

        // sop and eop together is always a violation for N > 1
        drive_src(1'b1, 1'b1, 6'h01, 16'd7);
        tick();
        checks++; if (ifa.frame_err !== 1'b1) begin failures++; $display("FAIL fe_sop_eop actual=%0b required=1", ifa.frame_err); end
        checks++; if (ifa.dout_index !== 6'd0) begin failures++; $display("FAIL fe_sop_eop_idx actual=%0d required=0", ifa.dout_index); end
        ifa.source_valid = 0;
        tick();
    endtask

    task automatic test_reset_midframe;
        // dut_a input side sits at in_cnt = 20 with inverse = 1
        ifa.dout_ready  = 0;
        drive_src(1'b0, 1'b0, 6'h07, 16'h1234);
        ifa.din_valid   = 1;
        ifa.din_real    = 16'h0055;
        ifa.din_inverse = 0;
        tick();
        checks++; if (ifa.sink_sop !== 1'b0) begin failures++; $display("FAIL rm_pre_sop actual=%0b required=0", ifa.sink_sop); end
        checks++; if (ifa.dout_valid !== 1'b1) begin failures++; $display("FAIL rm_pre_dout_valid actual=%0b required=1", ifa.dout_valid); end
        idle_inputs();
        ifa.dout_ready = 0;
        rst_a_n = 0;
        tick();
        checks++; if (ifa.sink_valid !== 1'b0) begin failures++; $display("FAIL rm_sink_valid actual=%0b required=0", ifa.sink_valid); end
        checks++; if (ifa.sink_real !== 16'h0) begin failures++; $display("FAIL rm_sink_real actual=%0h required=0", ifa.sink_real); end
        checks++; if (ifa.inverse !== 1'b0) begin failures++; $display("FAIL rm_inverse actual=%0b required=0", ifa.inverse); end
        checks++; if (ifa.dout_valid !== 1'b0) begin failures++; $display("FAIL rm_dout_valid actual=%0b required=0", ifa.dout_valid); end
        checks++; if (ifa.dout_real !== 16'h0) begin failures++; $display("FAIL rm_dout_real actual=%0h required=0", ifa.dout_real); end
        checks++; if (ifa.dout_exp !== 6'h0) begin failures++; $display("FAIL rm_dout_exp actual=%0h required=0", ifa.dout_exp); end
        checks++; if (ifa.frame_err !== 1'b0) begin failures++; $display("FAIL rm_frame_err actual=%0b required=0", ifa.frame_err); end
        rst_a_n = 1;
        ifa.dout_ready = 1;
        tick();
        ifa.din_valid = 1;
        ifa.din_real  = 16'h0077;
        tick();
        checks++; if (ifa.sink_sop !== 1'b1) begin failures++; $display("FAIL rm_next_sop actual=%0b required=1", ifa.sink_sop); end
        checks++; if (ifa.sink_real !== 16'h0077) begin failures++; $display("FAIL rm_next_real actual=%0h required=77", ifa.sink_real); end
        ifa.din_valid = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gapped_inverse();
        test_backpressure();
        test_core_output();
        test_frame_error();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
